// File: rtl/cic2_conv_ctrl.sv
// Conversion sequencer for the sinc2 decimator: range-checks the decimation
// factor, pulses the filter reset, waits for done with timeout, holds result.
module cic2_conv_ctrl #(
    parameter int DW        = 19,
    parameter int MW        = 10,
    parameter int M_MIN     = 2,
    parameter int M_MAX     = 512,
    parameter int RST_CYC   = 4,
    parameter int TO_MARGIN = 16,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          start,
    input  logic          cont,
    input  logic [MW-1:0] m_cfg,
    output logic          busy,
    output logic          cic_rst,
    output logic [MW-1:0] cic_m,
    input  logic          cic_done,
    input  logic [DW-1:0] cic_dout,
    output logic [DW-1:0] res_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          err_cfg,
    output logic          err_timeout,
    output logic [CW-1:0] conv_cnt
);

    localparam int LW = MW + 2;

    localparam logic [MW:0]   M_LO     = (MW+1)'(M_MIN);
    localparam logic [MW:0]   M_HI     = (MW+1)'(M_MAX);
    localparam logic [LW-1:0] RST_LAST = LW'(RST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_CAPTURE,
        S_HOLD
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [LW-1:0] cnt;
    logic [LW-1:0] cnt_nx;
    logic [LW-1:0] cnt_inc;
    logic [LW-1:0] limit;
    logic          done_q;
    logic          m_ok;
    logic          accept;
    logic          cfg_bad;
    logic          timeout;
    logic          handshake;

    assign m_ok = ({1'b0, m_cfg} >= M_LO) && ({1'b0, m_cfg} <= M_HI);

    // 2*M + margin fits in MW+2 bits for any MW-bit factor
    assign limit     = LW'({cic_m, 1'b0}) + LW'(TO_MARGIN);
    assign cnt_inc   = cnt + LW'(1);
    assign handshake = res_valid && res_ready;
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        cfg_bad  = 1'b0;
        timeout  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (m_ok) begin
                        accept   = 1'b1;
                        cnt_nx   = '0;
                        state_nx = S_RESET;
                    end else begin
                        cfg_bad = 1'b1;
                    end
                end
            end
            S_RESET: begin
                if (cnt == RST_LAST) begin
                    cnt_nx   = '0;
                    state_nx = S_RUN;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            S_RUN: begin
                cnt_nx = cnt_inc;
                // a done seen on the limit cycle still counts as success
                if (done_q) begin
                    state_nx = S_CAPTURE;
                end else if (cnt_inc == limit) begin
                    timeout  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_CAPTURE: begin
                state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (handshake) begin
                    cnt_nx   = '0;
                    state_nx = cont ? S_RESET : S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state       <= S_IDLE;
            cnt         <= '0;
            done_q      <= 1'b0;
            cic_rst     <= 1'b1;
            cic_m       <= '0;
            res_data    <= '0;
            res_valid   <= 1'b0;
            err_cfg     <= 1'b0;
            err_timeout <= 1'b0;
            conv_cnt    <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            done_q  <= cic_done && (state == S_RUN);
            // registered from next state so the filter reset is glitch-free
            cic_rst <= (state_nx == S_IDLE) || (state_nx == S_RESET);
            err_cfg <= cfg_bad;

            if (accept) begin
                cic_m       <= m_cfg;
                err_timeout <= 1'b0;
            end else if (timeout) begin
                err_timeout <= 1'b1;
            end

            if (state == S_CAPTURE) begin
                res_data  <= cic_dout;
                res_valid <= 1'b1;
                conv_cnt  <= conv_cnt + CW'(1);
            end else if (handshake) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule
